// File: rtl/pwm_cfg_sequencer.sv
// Configuration sequencer: pops two-word commands from the SPI receive FIFO into
// per-channel shadow registers and commits them to the PWM channels at period ends.
module pwm_cfg_sequencer #(
  parameter int          DATA_W = 16,
  parameter int          NUM_CH = 4,
  parameter logic [3:0]  MAGIC  = 4'hC,
  parameter int          ERR_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_fifo_empty,
  input  logic [DATA_W-1:0]        i_fifo_data,
  output logic                     o_fifo_re,
  input  logic [NUM_CH-1:0]        i_pwm_done,
  output logic [NUM_CH*DATA_W-1:0] o_duty,
  output logic [NUM_CH*DATA_W-1:0] o_final_value,
  output logic [NUM_CH-1:0]        o_ready,
  output logic [NUM_CH-1:0]        o_pending,
  output logic                     o_busy,
  output logic [ERR_W-1:0]         o_err_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] DWAIT = 2'd2;
  localparam logic [1:0] DAT   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              pop;
  logic              hdr_ok;
  logic [CH_W-1:0]   cmd_chan;
  logic              cmd_imm;
  logic              cmd_field;
  logic [ERR_W-1:0]  err_cnt;

  logic [DATA_W-1:0] shadow_duty     [NUM_CH];
  logic [DATA_W-1:0] shadow_fv       [NUM_CH];
  logic [DATA_W-1:0] act_duty        [NUM_CH];
  logic [DATA_W-1:0] act_fv          [NUM_CH];
  logic [DATA_W-1:0] shadow_duty_nxt [NUM_CH];
  logic [DATA_W-1:0] shadow_fv_nxt   [NUM_CH];
  logic [DATA_W-1:0] act_duty_nxt    [NUM_CH];
  logic [DATA_W-1:0] act_fv_nxt      [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] pending_nxt;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] write_hit;
  logic [NUM_CH-1:0] force_commit;

  assign hdr_ok = (i_fifo_data[DATA_W-1 -: 4] == MAGIC);

  // The pop strobe is combinational so the popped word is on i_fifo_data in the next state;
  // gating with reset_n keeps the FIFO untouched while reset is held.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!i_fifo_empty) begin
          pop       = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        state_nxt = hdr_ok ? DWAIT : IDLE;
      end
      DWAIT: begin
        if (!i_fifo_empty) begin
          pop       = 1'b1;
          state_nxt = DAT;
        end
      end
      DAT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign o_fifo_re = pop & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_chan  <= '0;
      cmd_imm   <= 1'b0;
      cmd_field <= 1'b0;
    end else if (state == HDR && hdr_ok) begin
      cmd_chan  <= i_fifo_data[8 +: CH_W];
      cmd_imm   <= i_fifo_data[1];
      cmd_field <= i_fifo_data[0];
    end
  end

  // A rejected header is simply dropped, which lets the stream resync on the next word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (state == HDR && !hdr_ok && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      write_hit[n]    = (state == DAT) && (cmd_chan == CH_W'(n));
      force_commit[n] = write_hit[n] && (cmd_imm || (act_fv[n] == '0));
    end
  end

  // The commit reads the post-write shadow, so a write landing on a done pulse is
  // consumed by that same commit and leaves nothing pending.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      shadow_duty_nxt[n] = shadow_duty[n];
      shadow_fv_nxt[n]   = shadow_fv[n];
      act_duty_nxt[n]    = act_duty[n];
      act_fv_nxt[n]      = act_fv[n];
      pending_nxt[n]     = pending[n];
      if (write_hit[n]) begin
        if (cmd_field) begin
          shadow_fv_nxt[n] = i_fifo_data;
        end else begin
          shadow_duty_nxt[n] = i_fifo_data;
        end
        pending_nxt[n] = 1'b1;
      end
      if (pending_nxt[n] && (i_pwm_done[n] || force_commit[n])) begin
        act_duty_nxt[n] = shadow_duty_nxt[n];
        act_fv_nxt[n]   = shadow_fv_nxt[n];
        pending_nxt[n]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_duty[n] <= '0;
        shadow_fv[n]   <= '0;
        act_duty[n]    <= '0;
        act_fv[n]      <= '0;
      end
      pending <= '0;
      ready   <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_duty[n] <= shadow_duty_nxt[n];
        shadow_fv[n]   <= shadow_fv_nxt[n];
        act_duty[n]    <= act_duty_nxt[n];
        act_fv[n]      <= act_fv_nxt[n];
        ready[n]       <= (act_fv_nxt[n] != '0);
      end
      pending <= pending_nxt;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign o_duty[g*DATA_W +: DATA_W]        = act_duty[g];
    assign o_final_value[g*DATA_W +: DATA_W] = act_fv[g];
  end

  assign o_ready   = ready;
  assign o_pending = pending;
  assign o_busy    = (state != IDLE);
  assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Bench for pwm_cfg_sequencer: a word-level command model predicts every output each
// cycle under directed and random FIFO traffic, with a few hand-computed anchors.
module tb_pwm_cfg_sequencer;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int EW = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           i_fifo_empty;
  logic [DW-1:0]  i_fifo_data;
  logic           o_fifo_re;
  logic [NC-1:0]  i_pwm_done;
  logic [NC*DW-1:0] o_duty;
  logic [NC*DW-1:0] o_final_value;
  logic [NC-1:0]  o_ready;
  logic [NC-1:0]  o_pending;
  logic           o_busy;
  logic [EW-1:0]  o_err_cnt;

  always #5 clk = ~clk;

  pwm_cfg_sequencer #(.DATA_W(DW), .NUM_CH(NC), .MAGIC(4'hC), .ERR_W(EW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_data(i_fifo_data),
    .o_fifo_re(o_fifo_re),
    .i_pwm_done(i_pwm_done),
    .o_duty(o_duty),
    .o_final_value(o_final_value),
    .o_ready(o_ready),
    .o_pending(o_pending),
    .o_busy(o_busy),
    .o_err_cnt(o_err_cnt)
  );

  logic [15:0] fifo_q[$];
  logic [15:0] data_hold;
  logic        push_valid;
  logic [15:0] push_word;

  logic [15:0] m_duty[NC];
  logic [15:0] m_fv[NC];
  logic [15:0] m_sd[NC];
  logic [15:0] m_sf[NC];
  logic [NC-1:0] m_pend;
  int          m_err;
  bit          m_in_flight;
  bit          m_expect_data;
  logic [15:0] m_word;
  int          m_chan;
  bit          m_imm;
  bit          m_field;
  int          m_force_ch;
  bit          m_was_in_flight;

  int          vec_cnt = 0;
  int          miss_cnt = 0;
  logic        obs_re;
  bit          checking = 0;
  int          lit_seq = 0;
  int          lit_seen = 0;
  int          lit_n = 0;
  int          lit_sel[4];
  logic [63:0] lit_exp[4];
  logic [63:0] exp_duty;
  logic [63:0] exp_fv;
  logic [3:0]  exp_ready;
  bit          gen_hdr = 1;

  // One popped word per call: headers set up the command, data words write the shadow.
  task automatic modelWord(input logic [15:0] w);
    m_force_ch = -1;
    if (!m_expect_data) begin
      if (w[15:12] != 4'hC) begin
        if (m_err < 255) m_err++;
      end else begin
        m_chan        = int'(w[9:8]);
        m_imm         = w[1];
        m_field       = w[0];
        m_expect_data = 1;
      end
    end else begin
      if (m_field) m_sf[m_chan] = w;
      else         m_sd[m_chan] = w;
      m_pend[m_chan] = 1'b1;
      if (m_imm || m_fv[m_chan] == 16'h0) m_force_ch = m_chan;
      m_expect_data = 0;
    end
  endtask

  // Model plus FIFO environment: a popped word is acted on one cycle after its pop.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int n = 0; n < NC; n++) begin
        m_duty[n] = 16'h0; m_fv[n] = 16'h0; m_sd[n] = 16'h0; m_sf[n] = 16'h0;
      end
      m_pend = 4'h0; m_err = 0; m_in_flight = 0; m_expect_data = 0; m_force_ch = -1;
    end else begin
      m_was_in_flight = m_in_flight;
      m_force_ch = -1;
      if (m_in_flight) begin
        modelWord(m_word);
        m_in_flight = 0;
      end
      for (int n = 0; n < NC; n++) begin
        if (m_pend[n] && (i_pwm_done[n] || m_force_ch == n)) begin
          m_duty[n] = m_sd[n];
          m_fv[n]   = m_sf[n];
          m_pend[n] = 1'b0;
        end
      end
      if (!m_was_in_flight && fifo_q.size() > 0) begin
        m_in_flight = 1;
        m_word = fifo_q[0];
      end
    end
    if (obs_re === 1'b1 && fifo_q.size() > 0) data_hold = fifo_q.pop_front();
    if (push_valid) fifo_q.push_back(push_word);
    #1;
    i_fifo_data  = data_hold;
    i_fifo_empty = (fifo_q.size() == 0);
  end

  function automatic logic [63:0] getOut(input int sel);
    case (sel)
      0:  getOut = 64'(o_fifo_re);
      1:  getOut = 64'(o_busy);
      2:  getOut = 64'(o_err_cnt);
      3:  getOut = 64'(o_pending);
      4:  getOut = 64'(o_ready);
      10, 11, 12, 13: getOut = 64'(o_duty[(sel-10)*16 +: 16]);
      20, 21, 22, 23: getOut = 64'(o_final_value[(sel-20)*16 +: 16]);
      30: getOut = 64'(fifo_q.size()) + 64'(m_in_flight);
      default: getOut = 64'hDEAD;
    endcase
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the clock edge.
  always @(negedge clk) begin
    #2;
    obs_re = o_fifo_re;
    if (checking) begin
      for (int n = 0; n < NC; n++) begin
        exp_duty[n*16 +: 16] = m_duty[n];
        exp_fv[n*16 +: 16]   = m_fv[n];
        exp_ready[n]         = (m_fv[n] != 16'h0);
      end
      checkOutput("fifo_re", 64'(o_fifo_re),
                  64'(reset_n && !m_in_flight && fifo_q.size() > 0));
      checkOutput("busy", 64'(o_busy), 64'(m_in_flight || m_expect_data));
      checkOutput("err_cnt", 64'(o_err_cnt), 64'(m_err));
      checkOutput("pending", 64'(o_pending), 64'(m_pend));
      checkOutput("ready", 64'(o_ready), 64'(exp_ready));
      checkOutput("duty", o_duty, exp_duty);
      checkOutput("final_value", o_final_value, exp_fv);
      if (lit_seq != lit_seen) begin
        for (int i = 0; i < lit_n; i++)
          checkOutput($sformatf("literal_sel%0d", lit_sel[i]), getOut(lit_sel[i]), lit_exp[i]);
        lit_seen = lit_seq;
      end
    end
  end

  task automatic expectLit(input int n,
                           input int s0, input logic [63:0] e0,
                           input int s1, input logic [63:0] e1,
                           input int s2, input logic [63:0] e2);
    lit_n = n;
    lit_sel[0] = s0; lit_exp[0] = e0;
    lit_sel[1] = s1; lit_exp[1] = e1;
    lit_sel[2] = s2; lit_exp[2] = e2;
    lit_seq++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] w);
    push_valid = 1'b1;
    push_word  = w;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic pulseDone(input logic [3:0] mask);
    i_pwm_done = mask;
    @(negedge clk);
    i_pwm_done = 4'h0;
  endtask

  task automatic waitIdle(input int maxc);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || m_in_flight) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (k >= maxc) expectLit(1, 30, 64'h0, 0, 64'h0, 0, 64'h0);
  endtask

  task automatic genWord(output logic [15:0] w);
    if (gen_hdr) begin
      if ($urandom_range(0, 9) == 0) begin
        w = {4'h3, 12'($urandom)};
      end else begin
        w = {4'hC, 2'($urandom), 2'($urandom), 6'($urandom),
             1'($urandom_range(0, 4) == 0), 1'($urandom)};
        gen_hdr = 0;
      end
    end else begin
      w = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      gen_hdr = 1;
    end
  endtask

  initial begin
    logic [15:0] w;
    reset_n = 1'b0; push_valid = 1'b0; push_word = 16'h0;
    i_pwm_done = 4'h0; i_fifo_empty = 1'b1; i_fifo_data = 16'h0; data_hold = 16'h0;
    repeat (2) @(negedge clk);
    checking = 1;

    applyStimulus(16'hC001);
    expectLit(3, 0, 64'd0, 1, 64'd0, 20, 64'd0);
    reset_n = 1'b1;
    expectLit(1, 0, 64'd1, 0, 64'd0, 0, 64'd0);
    applyStimulus(16'h03E8);
    waitIdle(50);
    expectLit(3, 20, 64'd1000, 4, 64'h1, 3, 64'h0);

    applyStimulus(16'hC000);
    applyStimulus(16'h01F4);
    waitIdle(50);
    expectLit(2, 3, 64'h1, 10, 64'd0, 0, 64'h0);
    pulseDone(4'b0001);
    expectLit(2, 10, 64'd500, 3, 64'h0, 0, 64'h0);

    applyStimulus(16'hC201);
    applyStimulus(16'h00C8);
    applyStimulus(16'hC200);
    applyStimulus(16'h0064);
    waitIdle(50);
    expectLit(3, 3, 64'h4, 12, 64'd0, 4, 64'h5);
    pulseDone(4'b0100);
    expectLit(3, 12, 64'd100, 22, 64'd200, 3, 64'h0);

    applyStimulus(16'hC301);
    applyStimulus(16'h0100);
    applyStimulus(16'hC302);
    applyStimulus(16'h0050);
    waitIdle(50);
    expectLit(3, 13, 64'h50, 3, 64'h0, 23, 64'h100);

    applyStimulus(16'h1234);
    applyStimulus(16'hC101);
    applyStimulus(16'h0010);
    waitIdle(50);
    expectLit(3, 2, 64'd1, 21, 64'd16, 4, 64'hF);

    applyStimulus(16'hC000);
    repeat (10) @(negedge clk);
    expectLit(2, 1, 64'd1, 0, 64'd0, 0, 64'h0);
    applyStimulus(16'h0123);
    @(negedge clk);
    pulseDone(4'b0001);
    expectLit(2, 10, 64'h0123, 3, 64'h0, 0, 64'h0);

    repeat (256) applyStimulus(16'h5A5A);
    waitIdle(2000);
    expectLit(1, 2, 64'd255, 0, 64'h0, 0, 64'h0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        genWord(w);
        push_valid = 1'b1;
        push_word  = w;
      end else begin
        push_valid = 1'b0;
      end
      i_pwm_done = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      reset_n = !(i == 400 || i == 401);
      @(negedge clk);
    end
    push_valid = 1'b0;
    i_pwm_done = 4'h0;
    reset_n = 1'b1;
    waitIdle(3000);
    repeat (2) pulseDone(4'hF);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
